// File: rtl/alu_b_input_reg.sv
// ALU B operand register with one-level history (b_prev), restore swap,
// fixed-priority request arbitration and conflict flags.
module alu_b_input_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_not_db,
  input  logic             load_db,
  input  logic             load_adr,
  input  logic             load_zero,
  input  logic             restore,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] db,
  input  logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] b_prev,
  output logic             loaded,
  output logic             conflict,
  output logic             err_sticky
);

  logic [4:0]       req;
  logic             req_any;
  logic             req_multi;
  logic [WIDTH-1:0] b_out_q, b_out_d;
  logic [WIDTH-1:0] b_prev_q, b_prev_d;
  logic             loaded_q, conflict_q, err_q, err_d;

  assign req       = {load_not_db, load_db, load_adr, load_zero, restore};
  assign req_any   = |req;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign req_multi = |(req & (req - 5'd1));

  always_comb begin
    b_out_d  = b_out_q;
    b_prev_d = b_prev_q;
    if (load_not_db) begin
      b_out_d  = ~db;
      b_prev_d = b_out_q;
    end else if (load_db) begin
      b_out_d  = db;
      b_prev_d = b_out_q;
    end else if (load_adr) begin
      b_out_d  = adr;
      b_prev_d = b_out_q;
    end else if (load_zero) begin
      b_out_d  = '0;
      b_prev_d = b_out_q;
    end else if (restore) begin
      b_out_d  = b_prev_q;
      b_prev_d = b_out_q;
    end
  end

  // A fresh conflict outranks clr_err on the same edge.
  assign err_d = req_multi | (err_q & ~clr_err);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_out_q    <= RESET_VALUE;
      b_prev_q   <= RESET_VALUE;
      loaded_q   <= 1'b0;
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      b_out_q    <= b_out_d;
      b_prev_q   <= b_prev_d;
      loaded_q   <= req_any;
      conflict_q <= req_multi;
      err_q      <= err_d;
    end
  end

  assign b_out      = b_out_q;
  assign b_prev     = b_prev_q;
  assign loaded     = loaded_q;
  assign conflict   = conflict_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_alu_b_input_reg.sv
// Directed self-checking bench for alu_b_input_reg: an 8-bit instance with
// zero reset value and a 16-bit instance resetting to 0xFFFF.
module tb_alu_b_input_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_not_db, load_db, load_adr, load_zero, restore, clr_err;
  logic [7:0]  db, adr;
  logic [7:0]  b_out, b_prev;
  logic        loaded, conflict, err_sticky;

  logic        lz16;
  logic        zero1;
  logic [15:0] zero16;
  logic [15:0] b_out16, b_prev16;
  logic        loaded16, conflict16, err16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_b_input_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .load_not_db(load_not_db), .load_db(load_db), .load_adr(load_adr),
    .load_zero(load_zero), .restore(restore), .clr_err(clr_err),
    .db(db), .adr(adr),
    .b_out(b_out), .b_prev(b_prev),
    .loaded(loaded), .conflict(conflict), .err_sticky(err_sticky)
  );

  alu_b_input_reg #(.WIDTH(16), .RESET_VALUE(16'hFFFF)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .load_not_db(zero1), .load_db(zero1), .load_adr(zero1),
    .load_zero(lz16), .restore(zero1), .clr_err(zero1),
    .db(zero16), .adr(zero16),
    .b_out(b_out16), .b_prev(b_prev16),
    .loaded(loaded16), .conflict(conflict16), .err_sticky(err16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    load_not_db = 0; load_db = 0; load_adr = 0; load_zero = 0; restore = 0; clr_err = 0;
    lz16 = 0;
  endtask

  task automatic chk8(input string tag, input logic [7:0] eo, input logic [7:0] ep,
                      input logic el, input logic ec, input logic ee);
    check({tag, ".b_out"},  b_out,      eo);
    check({tag, ".b_prev"}, b_prev,     ep);
    check({tag, ".loaded"}, loaded,     el);
    check({tag, ".conf"},   conflict,   ec);
    check({tag, ".err"},    err_sticky, ee);
  endtask

  initial begin
    zero1 = 0; zero16 = '0;
    idle_req();
    db = '0; adr = '0;
    rst_n = 0;
    step(); step();
    chk8("reset", 8'h00, 8'h00, 0, 0, 0);
    check("reset16.b_out",  b_out16,  16'hFFFF);
    check("reset16.b_prev", b_prev16, 16'hFFFF);

    rst_n = 1;
    db = 8'h5A; load_db = 1; lz16 = 1;
    step();
    chk8("ld_db", 8'h5A, 8'h00, 1, 0, 0);
    check("w16_zero.b_out",  b_out16,  16'h0000);
    check("w16_zero.b_prev", b_prev16, 16'hFFFF);
    check("w16_zero.loaded", loaded16, 1'b1);

    idle_req(); db = 8'h0F; load_not_db = 1;
    step();
    chk8("ld_not_db", 8'hF0, 8'h5A, 1, 0, 0);
    idle_req(); restore = 1;
    step();
    chk8("restore1", 8'h5A, 8'hF0, 1, 0, 0);
    step();
    chk8("restore2", 8'hF0, 8'h5A, 1, 0, 0);
    idle_req();
    step();
    chk8("hold", 8'hF0, 8'h5A, 0, 0, 0);

    db = 8'h11; adr = 8'h22; load_db = 1; load_adr = 1;
    step();
    chk8("conf_db_adr", 8'h11, 8'hF0, 1, 1, 1);
    idle_req();
    step();
    chk8("err_held", 8'h11, 8'hF0, 0, 0, 1);
    clr_err = 1;
    step();
    chk8("clr_err", 8'h11, 8'hF0, 0, 0, 0);

    idle_req(); adr = 8'h33; load_adr = 1; load_zero = 1; clr_err = 1;
    step();
    chk8("set_beats_clr", 8'h33, 8'h11, 1, 1, 1);
    idle_req();
    step();
    chk8("err_held2", 8'h33, 8'h11, 0, 0, 1);
    clr_err = 1;
    step();
    chk8("clr_err2", 8'h33, 8'h11, 0, 0, 0);

    idle_req(); load_adr = 1;
    step();
    chk8("same_val", 8'h33, 8'h33, 1, 0, 0);

    idle_req(); db = 8'hC3; load_zero = 1; restore = 1;
    step();
    chk8("zero_over_restore", 8'h00, 8'h33, 1, 1, 1);
    idle_req(); db = 8'hC3; load_not_db = 1; load_db = 1; load_adr = 1; clr_err = 1;
    step();
    chk8("not_db_top", 8'h3C, 8'h00, 1, 1, 1);

    idle_req(); db = 8'h77; load_db = 1;
    step();
    chk8("ld_77", 8'h77, 8'h3C, 1, 0, 1);
    idle_req(); adr = 8'hAA; load_adr = 1; clr_err = 1; rst_n = 0;
    step();
    chk8("rst_over_req", 8'h00, 8'h00, 0, 0, 0);
    idle_req(); rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk8($sformatf("idle%0d", i), 8'h00, 8'h00, 0, 0, 0);
    end

    db = 8'h44; load_db = 1;
    step();
    db = 8'h55;
    step();
    chk8("pre_swap", 8'h55, 8'h44, 1, 0, 0);
    idle_req(); restore = 1;
    step();
    chk8("mid_swap", 8'h44, 8'h55, 1, 0, 0);
    idle_req(); rst_n = 0;
    step();
    rst_n = 1; restore = 1;
    step();
    chk8("swap_after_rst", 8'h00, 8'h00, 1, 0, 0);
    idle_req();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
